// File: rtl/aes_input_loader.sv
// Command-driven loader that assembles an AES plaintext block and a 128/192/256-bit key
// from a DIN_W-wide beat stream, then holds key_start until the engine reports done.
module aes_input_loader #(
   parameter int DIN_W = 8
) (
   input  logic               clk,
   input  logic               rst_,
   input  logic [2:0]         cmd,
   input  logic               cmd_valid,
   input  logic [1:0]         key_len,
   input  logic [DIN_W-1:0]   din,
   input  logic               din_valid,
   output logic               din_ready,
   output logic               ready,
   input  logic               transformer_done,
   output logic               key_start,
   output logic [127:0]       plain_out,
   output logic [255:0]       key_out,
   output logic [1:0]         key_len_out,
   output logic               pt_loaded,
   output logic               key_loaded,
   output logic               err
);

   localparam int PT_BEATS = 128 / DIN_W;
   localparam int CNT_W    = 6;

   localparam logic [2:0] CMD_NOP      = 3'b000;
   localparam logic [2:0] CMD_LOAD_PT  = 3'b001;
   localparam logic [2:0] CMD_LOAD_KEY = 3'b010;
   localparam logic [2:0] CMD_START    = 3'b011;
   localparam logic [2:0] CMD_CLEAR    = 3'b100;

   typedef enum logic [1:0] {S_IDLE, S_LOAD_PT, S_LOAD_KEY, S_RUN} state_t;

   state_t             state, state_nxt;
   logic [CNT_W-1:0]   cnt;
   logic [CNT_W-1:0]   key_last;
   logic [1:0]         len_pend;
   logic               reject;
   logic               pt_last;
   logic               key_done;

   // Key beats enter at the bottom of the active K-bit field; bits below the field stay zero.
   function automatic logic [255:0] key_shift(input logic [255:0] k,
                                              input logic [DIN_W-1:0] d,
                                              input logic [1:0] len);
      logic [255:0] ext;
      ext = {{(256-DIN_W){1'b0}}, d};
      case (len)
         2'b00:   ext = ext << 128;
         2'b01:   ext = ext << 64;
         default: ext = ext;
      endcase
      return (k << DIN_W) | ext;
   endfunction

   always_comb begin
      case (len_pend)
         2'b00:   key_last = CNT_W'(128 / DIN_W - 1);
         2'b01:   key_last = CNT_W'(192 / DIN_W - 1);
         default: key_last = CNT_W'(256 / DIN_W - 1);
      endcase
   end

   assign pt_last  = (cnt == CNT_W'(PT_BEATS - 1));
   assign key_done = (cnt == key_last);

   always_ff @(posedge clk) begin
      if (rst_) state <= S_IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      din_ready = 1'b0;
      ready     = 1'b0;
      key_start = 1'b0;
      reject    = 1'b0;
      case (state)
         S_IDLE: begin
            ready = 1'b1;
            if (cmd_valid) begin
               case (cmd)
                  CMD_NOP:      ;
                  CMD_LOAD_PT:  state_nxt = S_LOAD_PT;
                  CMD_LOAD_KEY: if (key_len != 2'b11) state_nxt = S_LOAD_KEY;
                                else                  reject    = 1'b1;
                  CMD_START:    if (pt_loaded && key_loaded) state_nxt = S_RUN;
                                else                         reject    = 1'b1;
                  CMD_CLEAR:    ;
                  default:      reject = 1'b1;
               endcase
            end
         end
         S_LOAD_PT: begin
            din_ready = 1'b1;
            if (din_valid && pt_last) state_nxt = S_IDLE;
         end
         S_LOAD_KEY: begin
            din_ready = 1'b1;
            if (din_valid && key_done) state_nxt = S_IDLE;
         end
         S_RUN: begin
            key_start = 1'b1;
            if (transformer_done) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst_) begin
         plain_out   <= '0;
         key_out     <= '0;
         cnt         <= '0;
         len_pend    <= '0;
         key_len_out <= '0;
         pt_loaded   <= 1'b0;
         key_loaded  <= 1'b0;
         err         <= 1'b0;
      end else begin
         err <= reject;
         case (state)
            S_IDLE: begin
               if (cmd_valid) begin
                  case (cmd)
                     CMD_LOAD_PT: begin
                        plain_out <= '0;
                        pt_loaded <= 1'b0;
                        cnt       <= '0;
                     end
                     CMD_LOAD_KEY: if (key_len != 2'b11) begin
                        key_out    <= '0;
                        key_loaded <= 1'b0;
                        len_pend   <= key_len;
                        cnt        <= '0;
                     end
                     CMD_CLEAR: begin
                        plain_out  <= '0;
                        key_out    <= '0;
                        pt_loaded  <= 1'b0;
                        key_loaded <= 1'b0;
                     end
                     default: ;
                  endcase
               end
            end
            S_LOAD_PT: if (din_valid) begin
               plain_out <= {plain_out[127-DIN_W:0], din};
               if (pt_last) begin
                  pt_loaded <= 1'b1;
                  cnt       <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_LOAD_KEY: if (din_valid) begin
               key_out <= key_shift(key_out, din, len_pend);
               if (key_done) begin
                  key_loaded  <= 1'b1;
                  key_len_out <= len_pend;
                  cnt         <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_RUN: if (transformer_done) begin
               plain_out <= '0;
               pt_loaded <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_aes_input_loader.sv
// Directed bench for aes_input_loader: an 8-bit instance for most scenarios and a
// 32-bit instance for the wide-beat key load.
module tb_aes_input_loader;

   logic         clk = 1'b0;
   logic         rst_ = 1'b1;
   int           total = 0;
   int           bad = 0;

   logic [2:0]   cmd = 3'b000;
   logic         cmd_valid = 1'b0;
   logic [1:0]   key_len = 2'b00;
   logic [7:0]   din = 8'h00;
   logic         din_valid = 1'b0;
   logic         done = 1'b0;
   logic         din_ready, ready, key_start, pt_loaded, key_loaded, err;
   logic [127:0] plain_out;
   logic [255:0] key_out;
   logic [1:0]   key_len_out;

   logic [2:0]   w_cmd = 3'b000;
   logic         w_cmd_valid = 1'b0;
   logic [1:0]   w_key_len = 2'b00;
   logic [31:0]  w_din = 32'h0;
   logic         w_din_valid = 1'b0;
   logic         w_done = 1'b0;
   logic         w_din_ready, w_ready, w_key_start, w_pt_loaded, w_key_loaded, w_err;
   logic [127:0] w_plain_out;
   logic [255:0] w_key_out;
   logic [1:0]   w_key_len_out;

   always #5 clk = ~clk;

   aes_input_loader #(.DIN_W(8)) dut8 (
      .clk(clk), .rst_(rst_), .cmd(cmd), .cmd_valid(cmd_valid), .key_len(key_len),
      .din(din), .din_valid(din_valid), .din_ready(din_ready), .ready(ready),
      .transformer_done(done), .key_start(key_start), .plain_out(plain_out),
      .key_out(key_out), .key_len_out(key_len_out), .pt_loaded(pt_loaded),
      .key_loaded(key_loaded), .err(err)
   );

   aes_input_loader #(.DIN_W(32)) dut32 (
      .clk(clk), .rst_(rst_), .cmd(w_cmd), .cmd_valid(w_cmd_valid), .key_len(w_key_len),
      .din(w_din), .din_valid(w_din_valid), .din_ready(w_din_ready), .ready(w_ready),
      .transformer_done(w_done), .key_start(w_key_start), .plain_out(w_plain_out),
      .key_out(w_key_out), .key_len_out(w_key_len_out), .pt_loaded(w_pt_loaded),
      .key_loaded(w_key_loaded), .err(w_err)
   );

   // Observe one time unit after each rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_ = 1'b1;
      tick(); tick();
      rst_ = 1'b0;
      total++; if (ready !== 1'b1) begin $display("FAIL reset_ready got=%b exp=1", ready); bad++; end
      total++; if (din_ready !== 1'b0) begin $display("FAIL reset_din_ready got=%b exp=0", din_ready); bad++; end
      total++; if (plain_out !== 128'h0) begin $display("FAIL reset_plain got=%h exp=0", plain_out); bad++; end
      total++; if (key_out !== 256'h0) begin $display("FAIL reset_key got=%h exp=0", key_out); bad++; end
      total++; if ({pt_loaded, key_loaded, err, key_start} !== 4'b0000)
         begin $display("FAIL reset_flags got=%b exp=0000", {pt_loaded, key_loaded, err, key_start}); bad++; end
      total++; if (key_len_out !== 2'b00) begin $display("FAIL reset_key_len got=%b exp=00", key_len_out); bad++; end
   endtask

   task automatic test_load_key192();
      int idx = 0;
      int c = 0;
      cmd = 3'b010; key_len = 2'b01; cmd_valid = 1'b1;
      tick();
      cmd_valid = 1'b0;
      total++; if (din_ready !== 1'b1 || ready !== 1'b0)
         begin $display("FAIL key192_enter got=%b%b exp=10", din_ready, ready); bad++; end
      while (idx < 24) begin
         din_valid = (c % 3) != 2;
         din = 8'(8'hA0 + idx);
         tick();
         if (din_valid) idx++;
         c++;
         if (idx == 23 && din_valid) begin
            total++; if (key_loaded !== 1'b0) begin $display("FAIL key192_early got=%b exp=0", key_loaded); bad++; end
         end
      end
      din_valid = 1'b0;
      total++; if (key_out[255:64] !== 192'hA0A1A2A3A4A5A6A7A8A9AAABACADAEAFB0B1B2B3B4B5B6B7)
         begin $display("FAIL key192_value got=%h", key_out[255:64]); bad++; end
      total++; if (key_out[63:0] !== 64'h0) begin $display("FAIL key192_lsbs got=%h exp=0", key_out[63:0]); bad++; end
      total++; if (key_len_out !== 2'b01) begin $display("FAIL key192_len got=%b exp=01", key_len_out); bad++; end
      total++; if (key_loaded !== 1'b1 || ready !== 1'b1)
         begin $display("FAIL key192_done got=%b%b exp=11", key_loaded, ready); bad++; end
   endtask

   task automatic test_start_err();
      cmd = 3'b011; cmd_valid = 1'b1;
      tick();
      cmd_valid = 1'b0;
      total++; if (err !== 1'b1) begin $display("FAIL start_err_pulse got=%b exp=1", err); bad++; end
      total++; if (ready !== 1'b1 || key_start !== 1'b0)
         begin $display("FAIL start_err_state got=%b%b exp=10", ready, key_start); bad++; end
      tick();
      total++; if (err !== 1'b0) begin $display("FAIL start_err_width got=%b exp=0", err); bad++; end
   endtask

   task automatic test_load_pt();
      int errs = 0;
      cmd = 3'b001; cmd_valid = 1'b1;
      tick();
      cmd_valid = 1'b0;
      for (int i = 0; i < 16; i++) begin
         din = 8'(i); din_valid = 1'b1;
         tick();
         if (err) errs++;
         if (i == 14) begin
            total++; if (pt_loaded !== 1'b0) begin $display("FAIL pt_early got=%b exp=0", pt_loaded); bad++; end
         end
      end
      din_valid = 1'b0;
      total++; if (plain_out !== 128'h000102030405060708090A0B0C0D0E0F)
         begin $display("FAIL pt_value got=%h", plain_out); bad++; end
      total++; if (pt_loaded !== 1'b1 || ready !== 1'b1 || din_ready !== 1'b0)
         begin $display("FAIL pt_done got=%b%b%b exp=110", pt_loaded, ready, din_ready); bad++; end
      total++; if (errs !== 0) begin $display("FAIL pt_no_err got=%0d exp=0", errs); bad++; end
      total++; if (key_loaded !== 1'b1) begin $display("FAIL pt_key_kept got=%b exp=1", key_loaded); bad++; end
   endtask

   task automatic test_run();
      int drops = 0;
      cmd = 3'b011; cmd_valid = 1'b1;
      tick();
      cmd_valid = 1'b0;
      total++; if (key_start !== 1'b1 || ready !== 1'b0)
         begin $display("FAIL run_enter got=%b%b exp=10", key_start, ready); bad++; end
      for (int i = 0; i < 10; i++) begin
         din = 8'hEE; din_valid = 1'b1;
         cmd = 3'b100; cmd_valid = 1'b1;
         tick();
         if (key_start !== 1'b1 || plain_out !== 128'h000102030405060708090A0B0C0D0E0F) drops++;
      end
      din_valid = 1'b0; cmd_valid = 1'b0;
      total++; if (drops !== 0) begin $display("FAIL run_hold got=%0d exp=0", drops); bad++; end
      done = 1'b1;
      tick();
      done = 1'b0;
      total++; if (key_start !== 1'b0 || ready !== 1'b1)
         begin $display("FAIL run_exit got=%b%b exp=01", key_start, ready); bad++; end
      total++; if (pt_loaded !== 1'b0 || key_loaded !== 1'b1)
         begin $display("FAIL run_flags got=%b%b exp=01", pt_loaded, key_loaded); bad++; end
      total++; if (plain_out !== 128'h0) begin $display("FAIL run_plain got=%h exp=0", plain_out); bad++; end
      total++; if (key_out[255:64] !== 192'hA0A1A2A3A4A5A6A7A8A9AAABACADAEAFB0B1B2B3B4B5B6B7)
         begin $display("FAIL run_key_kept got=%h", key_out[255:64]); bad++; end
   endtask

   task automatic test_wide_key256();
      w_cmd = 3'b010; w_key_len = 2'b10; w_cmd_valid = 1'b1;
      tick();
      w_cmd_valid = 1'b0;
      total++; if (w_din_ready !== 1'b1) begin $display("FAIL wide_enter got=%b exp=1", w_din_ready); bad++; end
      for (int i = 0; i < 8; i++) begin
         w_din = 32'hDEADBEEF; w_din_valid = 1'b1;
         tick();
         if (i == 6) begin
            total++; if (w_key_loaded !== 1'b0) begin $display("FAIL wide_early got=%b exp=0", w_key_loaded); bad++; end
         end
      end
      w_din_valid = 1'b0;
      total++; if (w_key_loaded !== 1'b1 || w_ready !== 1'b1)
         begin $display("FAIL wide_done got=%b%b exp=11", w_key_loaded, w_ready); bad++; end
      total++; if (w_key_out !== {8{32'hDEADBEEF}}) begin $display("FAIL wide_value got=%h", w_key_out); bad++; end
      total++; if (w_key_len_out !== 2'b10) begin $display("FAIL wide_len got=%b exp=10", w_key_len_out); bad++; end
      w_cmd = 3'b100; w_cmd_valid = 1'b1;
      tick();
      w_cmd_valid = 1'b0;
      total++; if (w_key_out !== 256'h0 || w_key_loaded !== 1'b0)
         begin $display("FAIL wide_clear got=%h loaded=%b exp=0", w_key_out, w_key_loaded); bad++; end
      total++; if (w_err !== 1'b0 || w_key_start !== 1'b0 || w_pt_loaded !== 1'b0 || w_plain_out !== 128'h0)
         begin $display("FAIL wide_side got=%b%b%b exp=000", w_err, w_key_start, w_pt_loaded); bad++; end
   endtask

   task automatic test_midload_reset();
      cmd = 3'b001; cmd_valid = 1'b1;
      tick();
      cmd_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         din = 8'h55; din_valid = 1'b1;
         tick();
      end
      din_valid = 1'b0;
      rst_ = 1'b1;
      tick();
      rst_ = 1'b0;
      total++; if (plain_out !== 128'h0) begin $display("FAIL midrst_plain got=%h exp=0", plain_out); bad++; end
      total++; if (ready !== 1'b1 || din_ready !== 1'b0)
         begin $display("FAIL midrst_state got=%b%b exp=10", ready, din_ready); bad++; end
      total++; if (key_loaded !== 1'b0 || key_out !== 256'h0)
         begin $display("FAIL midrst_key got=%b exp=0", key_loaded); bad++; end
      cmd = 3'b001; cmd_valid = 1'b1;
      tick();
      cmd_valid = 1'b0;
      for (int i = 0; i < 16; i++) begin
         din = 8'(8'hF0 + i); din_valid = 1'b1;
         tick();
         if (i == 14) begin
            total++; if (pt_loaded !== 1'b0 || din_ready !== 1'b1)
               begin $display("FAIL midrst_count got=%b%b exp=01", pt_loaded, din_ready); bad++; end
         end
      end
      din_valid = 1'b0;
      total++; if (plain_out !== 128'hF0F1F2F3F4F5F6F7F8F9FAFBFCFDFEFF || pt_loaded !== 1'b1)
         begin $display("FAIL midrst_reload got=%h loaded=%b", plain_out, pt_loaded); bad++; end
   endtask

   task automatic test_illegal();
      int errs = 0;
      cmd = 3'b111; cmd_valid = 1'b1;
      tick();
      cmd_valid = 1'b0;
      total++; if (err !== 1'b1 || ready !== 1'b1)
         begin $display("FAIL illegal_cmd got=%b%b exp=11", err, ready); bad++; end
      tick();
      total++; if (err !== 1'b0) begin $display("FAIL illegal_cmd_width got=%b exp=0", err); bad++; end
      cmd = 3'b010; key_len = 2'b11; cmd_valid = 1'b1;
      tick();
      cmd_valid = 1'b0;
      total++; if (err !== 1'b1 || ready !== 1'b1 || din_ready !== 1'b0)
         begin $display("FAIL illegal_len got=%b%b%b exp=110", err, ready, din_ready); bad++; end
      tick();
      cmd = 3'b001; cmd_valid = 1'b1;
      tick();
      cmd_valid = 1'b0;
      for (int i = 0; i < 16; i++) begin
         din = 8'(8'h10 + i); din_valid = 1'b1;
         if (i == 3) begin cmd = 3'b010; key_len = 2'b00; cmd_valid = 1'b1; end
         else cmd_valid = 1'b0;
         tick();
         if (err) errs++;
      end
      din_valid = 1'b0; cmd_valid = 1'b0;
      total++; if (plain_out !== 128'h101112131415161718191A1B1C1D1E1F || pt_loaded !== 1'b1)
         begin $display("FAIL abort_ignored got=%h loaded=%b", plain_out, pt_loaded); bad++; end
      total++; if (key_loaded !== 1'b0 || ready !== 1'b1 || errs !== 0)
         begin $display("FAIL abort_side got=%b%b errs=%0d exp=01 0", key_loaded, ready, errs); bad++; end
      total++; if (plain_out === 128'h000102030405060708090A0B0C0D0E0F)
         begin $display("FAIL abort_stale got=%h", plain_out); bad++; end
   endtask

   initial begin
      test_reset();
      test_load_key192();
      test_start_err();
      test_load_pt();
      test_run();
      test_wide_key256();
      test_midload_reset();
      test_illegal();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
